// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: instruction field layout,
// special opcode encodings and the sequencer FSM state encoding.
package alu_sequencer_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 4;
    localparam int CNT_W  = 3;

    // Instruction word layout: [15:12] op, [11:8] rd, [7:4] rs1, [3:0] rs2.
    // Load-immediate reuses [7:0] as an 8-bit immediate.
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS1_MSB = 7;
    localparam int RS1_LSB = 4;
    localparam int RS2_MSB = 3;
    localparam int RS2_LSB = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    localparam logic [3:0] OP_MUL_ENC = 4'h2;
    localparam logic [3:0] OP_LDI_ENC = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_WB_LO = 2'd2,
        ST_WB_HI = 2'd3
    } seq_state_t;

    function automatic logic [3:0] instr_op(input logic [DATA_W-1:0] instr);
        return instr[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [3:0] instr_rd(input logic [DATA_W-1:0] instr);
        return instr[RD_MSB:RD_LSB];
    endfunction

    function automatic logic [3:0] instr_rs1(input logic [DATA_W-1:0] instr);
        return instr[RS1_MSB:RS1_LSB];
    endfunction

    function automatic logic [3:0] instr_rs2(input logic [DATA_W-1:0] instr);
        return instr[RS2_MSB:RS2_LSB];
    endfunction

    // Load-immediate value, zero-extended to the register width.
    function automatic logic [DATA_W-1:0] instr_imm(input logic [DATA_W-1:0] instr);
        return {8'h00, instr[IMM_MSB:IMM_LSB]};
    endfunction

endpackage

// File: rtl/alu_sequencer_regfile.sv
// 16x16 register file: one synchronous write port, two combinational
// operand read ports and a combinational debug read port. Cleared by reset.
module seq_regfile
    import alu_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [3:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [3:0]        raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] mem [16];

    // Register storage: cleared on reset, single write per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1   = mem[raddr1];
    assign rdata2   = mem[raddr2];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// ALU sequencer: accepts instruction words, reads operands from the local
// register file, issues them to an external fixed-latency ALU and writes
// the result (both halves for multiply) back. Load-immediate is handled
// locally in a single cycle.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int         ALU_LAT = 1,
    parameter logic [3:0] OP_MUL  = OP_MUL_ENC,
    parameter logic [3:0] OP_LDI  = OP_LDI_ENC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_ins,
    input  logic [15:0] alu_res,
    input  logic [15:0] alu_res_hi,
    output logic        done,
    output logic [3:0]  wb_addr,
    output logic [15:0] wb_data,
    input  logic [3:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    seq_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [3:0]        op_q;
    logic [3:0]        rd_q;

    logic [3:0]        in_op, in_rd, in_rs1, in_rs2;
    logic              accept, issue;

    logic              rf_we;
    logic [3:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rd1, rf_rd2;
    logic              done_d;

    assign in_op  = instr_op(in_instr);
    assign in_rd  = instr_rd(in_instr);
    assign in_rs1 = instr_rs1(in_instr);
    assign in_rs2 = instr_rs2(in_instr);

    // Ready only when idle and out of reset, so nothing is accepted mid-reset.
    assign in_ready = (state_q == ST_IDLE) && rst_n;
    assign accept   = in_valid && in_ready;
    assign issue    = accept && (in_op != OP_LDI);

    seq_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .raddr1   (in_rs1),
        .rdata1   (rf_rd1),
        .raddr2   (in_rs2),
        .rdata2   (rf_rd2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Next-state, register-file write port and retire pulse decode.
    always_comb begin
        state_d  = state_q;
        rf_we    = 1'b0;
        rf_waddr = rd_q;
        rf_wdata = alu_res;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (in_op == OP_LDI) begin
                        rf_we    = 1'b1;
                        rf_waddr = in_rd;
                        rf_wdata = instr_imm(in_instr);
                        done_d   = 1'b1;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                // Counter hits zero on this edge: ALU result is valid next edge.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_WB_LO;
                end
            end
            ST_WB_LO: begin
                rf_we    = 1'b1;
                rf_waddr = rd_q;
                rf_wdata = alu_res;
                if (op_q == OP_MUL) begin
                    state_d = ST_WB_HI;
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WB_HI: begin
                // High product half lands in rd+1; r15 wraps to r0.
                rf_we    = 1'b1;
                rf_waddr = rd_q + 4'd1;
                rf_wdata = alu_res_hi;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, wait counter, issued operands and writeback observation registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_ins <= '0;
            done    <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else begin
            state_q <= state_d;
            done    <= done_d;
            if (issue) begin
                alu_a   <= rf_rd1;
                alu_b   <= rf_rd2;
                alu_ins <= in_op;
                op_q    <= in_op;
                rd_q    <= in_rd;
                cnt_q   <= CNT_W'(ALU_LAT);
            end else if (state_q == ST_EXEC) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (rf_we) begin
                wb_addr <= rf_waddr;
                wb_data <= rf_wdata;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small fixed-latency ALU model.
module tb_alu_sequencer;

    localparam int ALU_LAT = 2;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_ins;
    logic [15:0] alu_res, alu_res_hi;
    logic        done;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    int n_cmp = 0;
    int n_bad = 0;

    alu_sequencer #(.ALU_LAT(ALU_LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ins    (alu_ins),
        .alu_res    (alu_res),
        .alu_res_hi (alu_res_hi),
        .done       (done),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: add, sub, fixed multiply result, byte pack; ALU_LAT-deep result register.
    function automatic logic [31:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [3:0] op);
        case (op)
            4'h0:    return {16'h0000, a + b};
            4'h1:    return {16'h0000, a - b};
            4'h2:    return 32'h00AD_BEEF;
            4'h3:    return {16'h0000, a[7:0], b[7:0]};
            default: return {16'h0000, a ^ b};
        endcase
    endfunction

    logic [31:0] alu_pipe [ALU_LAT];
    always @(posedge clk) begin
        alu_pipe[0] <= alu_fn(alu_a, alu_b, alu_ins);
        for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign alu_res    = alu_pipe[ALU_LAT-1][15:0];
    assign alu_res_hi = alu_pipe[ALU_LAT-1][31:16];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reg(input string tag, input logic [3:0] a, input logic [15:0] exp);
        dbg_addr = a;
        #1;
        check_eq(tag, {16'h0, dbg_data}, {16'h0, exp});
    endtask

    // Steps edges until done, returning the edge count and whether in_ready rose early.
    task automatic wait_done(output int n, output bit rdy_early);
        n = 0;
        rdy_early = 1'b0;
        do begin
            step();
            n++;
            if (!done && in_ready) rdy_early = 1'b1;
        end while (!done && n < 32);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  early;
        bit  held;
        bit  saw_done;
        bit  rdy_low;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_instr = 16'h0000;
        dbg_addr = 4'h0;

        // Reset state
        repeat (2) step();
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_alu_a", alu_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_eq("post_rst_ready", in_ready, 1);
        check_eq("post_rst_done", done, 0);
        for (int a = 0; a < 16; a++) check_reg($sformatf("rst_r%0d", a), 4'(a), 16'h0000);

        // Back-to-back LDI r1,0x34 ; LDI r2,0x12
        step();
        in_valid = 1'b1;
        in_instr = 16'hF134;
        step();
        check_eq("ldi1_done", done, 1);
        in_instr = 16'hF212;
        step();
        check_eq("ldi2_done", done, 1);
        check_eq("ldi2_wb_addr", wb_addr, 4'h2);
        check_eq("ldi2_wb_data", wb_data, 16'h0012);
        in_valid = 1'b0;
        step();
        check_eq("ldi_done_drop", done, 0);
        check_reg("ldi_r1", 4'h1, 16'h0034);
        check_reg("ldi_r2", 4'h2, 16'h0012);

        // ADD r3 = r1 + r2
        step();
        in_valid = 1'b1;
        in_instr = 16'h0312;
        step();
        in_valid = 1'b0;
        check_eq("add_alu_a", alu_a, 16'h0034);
        check_eq("add_alu_b", alu_b, 16'h0012);
        check_eq("add_alu_ins", alu_ins, 4'h0);
        check_eq("add_busy", in_ready, 0);
        check_eq("add_no_done", done, 0);
        wait_done(n, early);
        check_eq("add_latency", n, ALU_LAT + 1);
        check_eq("add_ready_early", early, 0);
        check_eq("add_wb_addr", wb_addr, 4'h3);
        check_eq("add_wb_data", wb_data, 16'h0046);
        check_reg("add_r3", 4'h3, 16'h0046);

        // MUL rd=15: lo to r15, hi wraps to r0
        step();
        in_valid = 1'b1;
        in_instr = 16'h2F12;
        step();
        in_valid = 1'b0;
        check_eq("mul_alu_ins", alu_ins, 4'h2);
        wait_done(n, early);
        check_eq("mul_latency", n, ALU_LAT + 2);
        check_eq("mul_ready_early", early, 0);
        check_eq("mul_wb_addr", wb_addr, 4'h0);
        check_eq("mul_wb_data", wb_data, 16'h00AD);
        check_reg("mul_r15", 4'hF, 16'hBEEF);
        check_reg("mul_r0", 4'h0, 16'h00AD);

        // Hold-off: SUB r4 = r3 - r1, then ADD r6 = r4 + r2 presented while busy
        step();
        in_valid = 1'b1;
        in_instr = 16'h1431;
        step();
        in_instr = 16'h0642;
        check_eq("hold_alu_ins", alu_ins, 4'h1);
        held = 1'b1;
        n = 0;
        do begin
            step();
            n++;
            if (!done && alu_ins !== 4'h1) held = 1'b0;
        end while (!done && n < 32);
        check_eq("hold_latency", n, ALU_LAT + 1);
        check_eq("hold_not_taken", held, 1);
        check_eq("hold_ready_at_done", in_ready, 1);
        step();
        in_valid = 1'b0;
        check_eq("hold2_alu_a", alu_a, 16'h0012);
        check_eq("hold2_alu_b", alu_b, 16'h0012);
        check_eq("hold2_alu_ins", alu_ins, 4'h0);
        wait_done(n, early);
        check_eq("hold2_latency", n, ALU_LAT + 1);
        check_reg("hold_r4", 4'h4, 16'h0012);
        check_reg("hold_r6", 4'h6, 16'h0024);

        // Build r5 = 0x1111 (LDI then byte pack), then reset during EXEC
        step();
        in_valid = 1'b1;
        in_instr = 16'hF511;
        step();
        in_instr = 16'h3555;
        step();
        in_valid = 1'b0;
        wait_done(n, early);
        check_eq("pack_latency", n, ALU_LAT + 1);
        check_reg("pack_r5", 4'h5, 16'h1111);
        step();
        in_valid = 1'b1;
        in_instr = 16'h0512;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check_eq("midrst_done", done, 0);
        check_eq("midrst_ready", in_ready, 0);
        check_eq("midrst_alu_a", alu_a, 0);
        repeat (2) step();
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        rdy_low  = 1'b0;
        repeat (6) begin
            step();
            if (done) saw_done = 1'b1;
            if (!in_ready) rdy_low = 1'b1;
        end
        check_eq("midrst_no_done", saw_done, 0);
        check_eq("midrst_idle", rdy_low, 0);
        check_reg("midrst_r5", 4'h5, 16'h0000);
        check_reg("midrst_r1", 4'h1, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Issuing end of the ALU operand/opcode interface.
- Accepts 16-bit instruction words over a valid/ready handshake and reads two source operands from an internal 16x16 register file.
- Drives A, B and ins into the ALU, waits the ALU's fixed latency, then writes the result back to the register file.
- Multiply writes back both the lo and hi halves; load-immediate is executed locally without using the ALU.

Parameters:
- ALU_LAT, 1: clock edges from ALU operands becoming stable to the ALU result register updating (legal range 1..7).
- OP_MUL, 4'h2: opcode whose result is a 32-bit product on alu_res/alu_res_hi.
- OP_LDI, 4'hF: local load-immediate opcode, never forwarded to the ALU.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction word present.
- in_ready  out  1  sequencer can accept an instruction.
- in_instr  in  16  [15:12] op, [11:8] rd, [7:4] rs1, [3:0] rs2; for LDI, [7:0] is imm8.
- alu_a  out  16  ALU operand A.
- alu_b  out  16  ALU operand B.
- alu_ins  out  4  ALU opcode.
- alu_res  in  16  ALU result, or product lo for MUL.
- alu_res_hi  in  16  product hi; used only for MUL.
- done  out  1  one-cycle pulse when an instruction retires.
- wb_addr  out  4  last register written.
- wb_data  out  16  last value written.
- dbg_addr  in  4  register-file read address for debug.
- dbg_data  out  16  combinational read of rf[dbg_addr].

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all 16 registers=0.
  - alu_a=alu_b=0, alu_ins=0, done=0, wb_addr=0, wb_data=0, in_ready=0 while reset is asserted.
  - Reset mid-instruction aborts it: no writeback, no done.
- FSM states: IDLE, EXEC, WB_LO, WB_HI.
- IDLE:
  - in_ready=1.
  - Handshake = in_valid & in_ready sampled at a rising edge E0.
  - Non-LDI op: at E0, alu_a<=rf[rs1], alu_b<=rf[rs2], alu_ins<=op; wait counter<=ALU_LAT; ->EXEC.
  - LDI: at E0, rf[rd]<={8'h00,imm8}, wb_addr/wb_data updated, done=1 for the following cycle; stays IDLE (back-to-back LDI every cycle is legal).
- EXEC:
  - in_ready=0; counter decrements each edge.
  - When the counter reaches 0 -> WB_LO. The result is therefore sampled at edge E0+ALU_LAT+1.
- WB_LO:
  - rf[rd]<=alu_res; wb_addr/wb_data updated.
  - If op==OP_MUL -> WB_HI; else done=1 next cycle and ->IDLE.
- WB_HI:
  - rf[(rd+1) mod 16]<=alu_res_hi (rd=15 wraps to r0); done=1 next cycle; ->IDLE.
- Latency from accept edge to retire edge: ALU_LAT+1 edges for non-MUL, ALU_LAT+2 for MUL. Next accept is possible on the edge after retire.
- alu_a/alu_b/alu_ins hold their values after issue until the next issue.
- Operands are read at acceptance, so rd==rs1/rs2 is safe. With one instruction in flight there are no hazards.
- in_valid while not ready: the instruction is held off, not dropped; the sender must keep in_instr stable.
- done is a registered single-cycle pulse, never asserted for two consecutive cycles except for back-to-back LDI.
- Arithmetic is entirely in the ALU; the sequencer performs no width conversion except LDI zero-extension.

Decomposition:
- Shared package: field positions for op/rd/rs1/rs2/imm8, the OP_MUL and OP_LDI encodings, and the FSM state encoding.
- Natural sub-module: seq_regfile (16x16, one synchronous write port, two combinational read ports plus one debug read port, async clear).

Test Plan:
- Reset: after rst_n release, dbg_data==0 for all 16 addresses, in_ready==1, done==0.
- LDI r1,0x34 then LDI r2,0x12 back-to-back -> r1==0x0034, r2==0x0012, done high two consecutive cycles.
- With r1=0x0034, r2=0x0012, issue op 4'h0 rd=3 rs1=1 rs2=2, ALU model returns 0x0046 -> alu_a==0x0034, alu_b==0x0012, alu_ins==0 the cycle after accept; r3==0x0046; done exactly ALU_LAT+1 edges after accept; in_ready low in between.
- MUL rd=15, ALU model returning lo=0xBEEF, hi=0x00AD -> r15==0xBEEF, r0==0x00AD (wrap); done ALU_LAT+2 edges after accept.
- Hold-off: in_valid held high during EXEC with a second instruction -> it is not accepted until the edge after done, then executes correctly.
- Reset asserted during EXEC of an op targeting r5 (r5 previously 0x1111) -> r5==0 after reset, done never pulses, state IDLE.
